// File: rtl/conv_frame_sched.sv
// rtl/conv_frame_sched.sv - frame sequencer with geometry tracking and flush-line injection
//
// Purpose: forwards a raw pixel stream frame-aligned, regenerates tlast/tuser
// from the geometry latched at start-of-frame, appends (KERNEL_DIAMETER_N-1)/2
// zero padding lines after each frame and flags stream-geometry errors.
//
// Ports:
//   clk_i, rst_n                 clock, asynchronous active-low reset
//   cfg_width_i, cfg_height_i    frame geometry, sampled when a SOF pixel is accepted
//   s_t*                         input pixel stream (tuser = SOF, tlast = end-of-line)
//   m_t*                         output pixel stream, one register slice; m_tpad_o marks padding
//   busy_o                       a frame or its flush is in progress
//   err_len_o, err_sof_o         one-cycle error pulses
module conv_frame_sched #(
  parameter int PIXEL_W           = 8,
  parameter int KERNEL_DIAMETER_N = 5,
  parameter int DIM_W             = 12
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic [DIM_W-1:0]   cfg_width_i,
  input  logic [DIM_W-1:0]   cfg_height_i,
  input  logic               s_tvalid_i,
  input  logic [PIXEL_W-1:0] s_tdata_i,
  input  logic               s_tlast_i,
  input  logic               s_tuser_i,
  output logic               s_tready_o,
  input  logic               m_tready_i,
  output logic               m_tvalid_o,
  output logic [PIXEL_W-1:0] m_tdata_o,
  output logic               m_tlast_o,
  output logic               m_tuser_o,
  output logic               m_tpad_o,
  output logic               busy_o,
  output logic               err_len_o,
  output logic               err_sof_o
);

  localparam int R = (KERNEL_DIAMETER_N - 1) / 2;
  localparam logic [DIM_W-1:0] ONE    = DIM_W'(1);
  localparam logic [DIM_W-1:0] R_LAST = DIM_W'((R > 0) ? R - 1 : 0);

  typedef enum logic [1:0] {IDLE, PASS, FLUSH} state_t;

  state_t           state;
  logic [DIM_W-1:0] w_q;
  logic [DIM_W-1:0] h_q;
  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row;

  logic             slice_free;
  logic             accept;
  logic             start;
  logic             mid_sof;
  logic             fwd;
  logic [DIM_W-1:0] eff_w;
  logic [DIM_W-1:0] eff_h;
  logic [DIM_W-1:0] eff_col;
  logic [DIM_W-1:0] eff_row;
  logic             line_end;
  logic             frame_end;
  logic             fl_line_end;
  logic             fl_end;

  assign slice_free = !m_tvalid_o || m_tready_i;
  assign s_tready_o = slice_free && (state != FLUSH);
  assign accept     = s_tvalid_i && s_tready_o;
  assign busy_o     = (state != IDLE);

  // A SOF pixel (from IDLE, or mid-frame as a restart) is positioned at (0,0)
  // of the freshly sampled geometry; everything else uses the latched frame.
  assign start   = accept && s_tuser_i;
  assign mid_sof = start && (state == PASS);
  assign fwd     = accept && ((state == PASS) || s_tuser_i);
  assign eff_w   = start ? cfg_width_i  : w_q;
  assign eff_h   = start ? cfg_height_i : h_q;
  assign eff_col = start ? '0 : col;
  assign eff_row = start ? '0 : row;

  assign line_end  = (eff_col == eff_w - ONE);
  assign frame_end = line_end && (eff_row == eff_h - ONE);

  assign fl_line_end = (col == w_q - ONE);
  assign fl_end      = fl_line_end && (row == R_LAST);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      w_q        <= '0;
      h_q        <= '0;
      col        <= '0;
      row        <= '0;
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tlast_o  <= 1'b0;
      m_tuser_o  <= 1'b0;
      m_tpad_o   <= 1'b0;
      err_len_o  <= 1'b0;
      err_sof_o  <= 1'b0;
    end else begin
      err_len_o <= 1'b0;
      err_sof_o <= 1'b0;
      // Slice empties when its beat is taken; a new load below overrides this.
      if (slice_free) begin
        m_tvalid_o <= 1'b0;
      end

      case (state)
        IDLE, PASS: begin
          if (fwd) begin
            m_tvalid_o <= 1'b1;
            m_tdata_o  <= s_tdata_i;
            m_tlast_o  <= line_end;
            m_tuser_o  <= start;
            m_tpad_o   <= 1'b0;
            err_len_o  <= (s_tlast_i != line_end);
            err_sof_o  <= mid_sof;
            if (start) begin
              w_q <= cfg_width_i;
              h_q <= cfg_height_i;
            end
            if (frame_end) begin
              col   <= '0;
              row   <= '0;
              state <= (R > 0) ? FLUSH : IDLE;
            end else if (line_end) begin
              col   <= '0;
              row   <= eff_row + ONE;
              state <= PASS;
            end else begin
              col   <= eff_col + ONE;
              row   <= eff_row;
              state <= PASS;
            end
          end
        end

        FLUSH: begin
          if (slice_free) begin
            m_tvalid_o <= 1'b1;
            m_tdata_o  <= '0;
            m_tlast_o  <= fl_line_end;
            m_tuser_o  <= 1'b0;
            m_tpad_o   <= 1'b1;
            if (fl_end) begin
              col   <= '0;
              row   <= '0;
              state <= IDLE;
            end else if (fl_line_end) begin
              col <= '0;
              row <= row + ONE;
            end else begin
              col <= col + ONE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_frame_sched.md
Name: conv_frame_sched

Overview:
- Frame sequencer in front of the streaming convolution datapath.
- Accepts the raw pixel stream and forwards it frame-aligned. Rebuilds tlast/tuser from a programmed geometry and tracks the row/column position.
- After the last pixel of each frame, injects (KERNEL_DIAMETER_N-1)/2 padding lines so the downstream line buffers drain fully.
- Detects and reports stream-geometry errors.

Parameters:
- PIXEL_W, 8, pixel width in bits
- KERNEL_DIAMETER_N, 5, kernel diameter; odd, >=1; flush line count R=(KERNEL_DIAMETER_N-1)/2
- DIM_W, 12, width of the geometry and position counters

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- cfg_width_i  in  DIM_W  pixels per line W; >=1; sampled at SOF acceptance
- cfg_height_i  in  DIM_W  lines per frame H; >=1; sampled at SOF acceptance
- s_tvalid_i  in  1  input pixel valid
- s_tdata_i  in  PIXEL_W  input pixel
- s_tlast_i  in  1  input end-of-line
- s_tuser_i  in  1  input start-of-frame
- s_tready_o  out  1  input ready
- m_tready_i  in  1  downstream ready
- m_tvalid_o  out  1  output valid
- m_tdata_o  out  PIXEL_W  output pixel (0 when padding)
- m_tlast_o  out  1  end-of-line, regenerated from the column counter
- m_tuser_o  out  1  start-of-frame: row 0, col 0
- m_tpad_o  out  1  pixel is injected flush padding
- busy_o  out  1  state != IDLE
- err_len_o  out  1  one-cycle pulse: s_tlast_i disagrees with the column position
- err_sof_o  out  1  one-cycle pulse: s_tuser_i seen mid-frame

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counters=0.
  - m_tvalid_o, m_tdata_o, m_tlast_o, m_tuser_o, m_tpad_o, busy_o, err_* all 0.
  - Output register empty.
- Output stage: one register slice. Latency is 1 cycle from input acceptance to m_tvalid_o.
  - Slice free = !m_tvalid_o || m_tready_i.
  - Output data is held stable while m_tvalid_o && !m_tready_i.
  - m_tvalid_o is never retracted before acceptance.
- s_tready_o = slice free && state in {IDLE, PASS}. It is 0 throughout FLUSH.
- Counters col (0..W-1) and row (0..H-1 in PASS, 0..R-1 in FLUSH). W and H are latched into internal registers at SOF.
- IDLE:
  - Accepted pixels with s_tuser_i=0 are discarded (consumed, not forwarded, no error).
  - An accepted pixel with s_tuser_i=1: latch W/H, forward with m_tuser_o=1, col/row advance from 0, go PASS.
  - If W=1 and H=1, that pixel also completes the frame; see the end-of-frame rule below.
- PASS, per accepted pixel:
  - Forward data with m_tlast_o=(col==W-1) and m_tpad_o=0.
  - If col==W-1: col<=0, row++. Otherwise col++.
  - If s_tlast_i != (col==W-1): pulse err_len_o. The pixel is still forwarded using the counter-derived tlast. Counters follow the counters, not s_tlast_i.
  - If s_tuser_i=1 and (row,col)!=(0,0): pulse err_sof_o, abandon the current frame with no flush, relatch W/H, treat the pixel as a new SOF (m_tuser_o=1), counters restart.
- End of frame: on accepting the pixel at row==H-1, col==W-1, go FLUSH if R>0, else IDLE. Counters are cleared.
- FLUSH:
  - Each cycle the slice is free, emit data=0, m_tpad_o=1, m_tuser_o=0, m_tlast_o=(col==W-1).
  - R*W pixels are emitted in total, then go IDLE.
  - The input is back-pressured for the whole of FLUSH.
- Boundary rules:
  - W=1: every pixel has m_tlast_o=1.
  - Counters never exceed W-1 / H-1. Wrap occurs exactly at the line and frame end.
  - cfg_* changes outside SOF acceptance have no effect on the frame in flight.
  - Reset mid-frame or mid-flush: all state is dropped immediately and no padding is completed.
  - err_len_o and err_sof_o may pulse in the same cycle.
- busy_o = 1 in PASS and FLUSH. It goes 0 in the cycle after the final flush pixel is loaded into the slice.

Test Plan:
- D=5, W=4, H=3, contiguous frame, m_tready=1 → 12 pixels out with tuser on the first and tlast on every 4th, then 8 pad pixels (data 0, m_tpad_o=1, tlast at 4 and 8); s_tready_o=0 for those 8 cycles; busy_o falls after them.
- Same frame with m_tready toggling 1/0 every cycle → identical output sequence, no data change while stalled, no loss or duplication.
- s_tlast_i asserted at col 2 of W=4 → err_len_o pulses once; output tlast still only at col 3; frame length unchanged.
- s_tuser_i at row 1, col 1 → err_sof_o pulses; no flush; that pixel is out with m_tuser_o=1 and a new 12-pixel frame follows.
- Idle pixels without tuser (5 pixels) before SOF → all consumed, none forwarded, no error.
- D=1, W=1, H=1, single SOF pixel → 1 output with tuser=tlast=1, no padding, straight back to IDLE; separately, assert rst_n=0 during FLUSH → all outputs 0 immediately, next SOF is handled normally.
